// File: rtl/nzcv_flag_gen_pkg.sv
// Shared definitions for NZCV flag generation and the condition evaluator.
// Flag-class encodings, NZCV bit positions and condition-code decode.
package nzcv_flag_gen_pkg;

    localparam logic [2:0] FLG_LOGIC = 3'b000;
    localparam logic [2:0] FLG_ADD   = 3'b001;
    localparam logic [2:0] FLG_SUB   = 3'b010;
    localparam logic [2:0] FLG_ADC   = 3'b011;
    localparam logic [2:0] FLG_SBC   = 3'b100;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
        CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
    } cond_code_e;

    function automatic logic cond_pass(input cond_code_e cc, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[NZCV_N];
        z = nzcv[NZCV_Z];
        c = nzcv[NZCV_C];
        v = nzcv[NZCV_V];
        case (cc)
            CC_EQ:   return z;
            CC_NE:   return !z;
            CC_CS:   return c;
            CC_CC:   return !c;
            CC_MI:   return n;
            CC_PL:   return !n;
            CC_VS:   return v;
            CC_VC:   return !v;
            CC_HI:   return c & !z;
            CC_LS:   return !c | z;
            CC_GE:   return n == v;
            CC_LT:   return n != v;
            CC_GT:   return !z & (n == v);
            CC_LE:   return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/nzcv_flag_gen_compute.sv
// Pure combinational NZCV arithmetic for one flag-setting ALU operation.
// Carry-in and overflow-in come from the most recent flags (forwarded).
module nzcv_compute
    import nzcv_flag_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic                  i_shift_carry,
    input  logic                  i_cin,
    input  logic                  i_vin,
    output logic [3:0]            o_nzcv
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] w_b_eff;
    logic                  w_carry_in;
    logic [DATA_WIDTH:0]   w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, w_b_eff} + {{DATA_WIDTH{1'b0}}, w_carry_in};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_b_eff    = i_b;
        w_carry_in = 1'b0;
        o_nzcv     = 4'b0000;
        case (i_op)
            FLG_ADD: w_carry_in = 1'b0;
            FLG_SUB: begin w_b_eff = ~i_b; w_carry_in = 1'b1; end
            FLG_ADC: w_carry_in = i_cin;
            FLG_SBC: begin w_b_eff = ~i_b; w_carry_in = i_cin; end
            default: ;
        endcase
        case (i_op)
            FLG_ADD, FLG_SUB, FLG_ADC, FLG_SBC: begin
                o_nzcv[NZCV_N] = w_sum[MSB];
                o_nzcv[NZCV_Z] = (w_sum[MSB:0] == '0);
                o_nzcv[NZCV_C] = w_sum[DATA_WIDTH];
                o_nzcv[NZCV_V] = (i_a[MSB] == w_b_eff[MSB]) & (w_sum[MSB] != i_a[MSB]);
            end
            FLG_LOGIC: begin
                o_nzcv[NZCV_N] = i_result[MSB];
                o_nzcv[NZCV_Z] = (i_result == '0);
                o_nzcv[NZCV_C] = i_shift_carry;
                o_nzcv[NZCV_V] = i_vin;
            end
            default: o_nzcv = 4'b0000;  // reserved classes are never captured
        endcase
    end

endmodule

// File: rtl/nzcv_flag_gen.sv
// NZCV producer: EX compute, one pipeline register (P), architectural commit,
// and forwarding of the newest flags to the branch-condition evaluator.
module nzcv_flag_gen
    import nzcv_flag_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  ex_set_flags,
    input  logic [2:0]            ex_op,
    input  logic [DATA_WIDTH-1:0] ex_a,
    input  logic [DATA_WIDTH-1:0] ex_b,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic                  ex_shift_carry,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  negative,
    output logic                  zero,
    output logic                  carry,
    output logic                  overflow,
    output logic [3:0]            arch_nzcv,
    output logic                  flags_pending
);

    logic [3:0] r_arch_nzcv;
    logic [3:0] r_p_nzcv;
    logic       r_p_valid;

    logic [3:0] w_fwd;
    logic [3:0] w_ex_nzcv;
    logic       w_capture;

    assign w_capture = ex_valid & ex_set_flags & (ex_op <= FLG_SBC);
    assign w_fwd     = r_p_valid ? r_p_nzcv : r_arch_nzcv;

    nzcv_compute #(.DATA_WIDTH(DATA_WIDTH)) u_compute (
        .i_op          (ex_op),
        .i_a           (ex_a),
        .i_b           (ex_b),
        .i_result      (ex_result),
        .i_shift_carry (ex_shift_carry),
        .i_cin         (w_fwd[NZCV_C]),
        .i_vin         (w_fwd[NZCV_V]),
        .o_nzcv        (w_ex_nzcv)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arch_nzcv <= 4'b0000;
            r_p_nzcv    <= 4'b0000;
            r_p_valid   <= 1'b0;
        end else begin
            if (!stall && r_p_valid && !flush)
                r_arch_nzcv <= r_p_nzcv;
            // NOTE: flush is checked before stall so a frozen pipe still drops a killed P entry.
            if (flush)
                r_p_valid <= 1'b0;
            else if (!stall)
                r_p_valid <= w_capture;
            if (!stall)
                r_p_nzcv <= w_ex_nzcv;
        end
    end

    assign negative      = !reset & w_fwd[NZCV_N];
    assign zero          = !reset & w_fwd[NZCV_Z];
    assign carry         = !reset & w_fwd[NZCV_C];
    assign overflow      = !reset & w_fwd[NZCV_V];
    assign arch_nzcv     = reset ? 4'b0000 : r_arch_nzcv;
    assign flags_pending = !reset & w_capture;

endmodule

// File: tb/tb_nzcv_flag_gen.sv
// Directed scoreboard bench for nzcv_flag_gen: each driven cycle queues the
// hand-computed outputs, and a negedge monitor pops and compares them.
module tb_nzcv_flag_gen;
    import nzcv_flag_gen_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ex_valid = 1'b0;
    logic          ex_set_flags = 1'b0;
    logic [2:0]    ex_op = 3'b000;
    logic [DW-1:0] ex_a = '0;
    logic [DW-1:0] ex_b = '0;
    logic [DW-1:0] ex_result = '0;
    logic          ex_shift_carry = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          negative, zero, carry, overflow, flags_pending;
    logic [3:0]    arch_nzcv;

    typedef struct {
        string      name;
        logic [3:0] fwd;
        logic [3:0] arch;
        logic       pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    nzcv_flag_gen #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_set_flags   (ex_set_flags),
        .ex_op          (ex_op),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_result      (ex_result),
        .ex_shift_carry (ex_shift_carry),
        .stall          (stall),
        .flush          (flush),
        .negative       (negative),
        .zero           (zero),
        .carry          (carry),
        .overflow       (overflow),
        .arch_nzcv      (arch_nzcv),
        .flags_pending  (flags_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("FAIL %s: got %b expected %b", name, actual, expected);
    endtask

    // One EX cycle: drive inputs just after the edge, queue what the outputs must show this cycle.
    task automatic step(input string name, input logic rst, input logic stl, input logic fls,
                        input logic vld, input logic s, input logic [2:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] res, input logic sc,
                        input logic [3:0] e_fwd, input logic [3:0] e_arch, input logic e_pend);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; stall = stl; flush = fls;
        ex_valid = vld; ex_set_flags = s; ex_op = op;
        ex_a = a; ex_b = b; ex_result = res; ex_shift_carry = sc;
        e.name = name; e.fwd = e_fwd; e.arch = e_arch; e.pend = e_pend;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, "_fwd"},  {negative, zero, carry, overflow}, e.fwd);
            check({e.name, "_arch"}, arch_nzcv, e.arch);
            check({e.name, "_pend"}, {3'b000, flags_pending}, {3'b000, e.pend});
        end
    end

    initial begin
        //   name          rst stl fls vld s  op         a             b             result        sc  fwd      arch     pend
        step("rst_gate",   1,  0,  0,  1,  1, FLG_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h0,        0,  4'b0000, 4'b0000, 0);
        step("add_ovf",    0,  0,  0,  1,  1, FLG_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h0,        0,  4'b0000, 4'b0000, 1);
        step("add_fwd",    0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b1001, 4'b0000, 0);
        step("add_arch",   0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b1001, 4'b1001, 0);
        step("sub_eq",     0,  0,  0,  1,  1, FLG_SUB,   32'd5,        32'd5,        32'h0,        0,  4'b1001, 4'b1001, 1);
        step("sub_lt",     0,  0,  0,  1,  1, FLG_SUB,   32'd3,        32'd5,        32'h0,        0,  4'b0110, 4'b1001, 1);
        step("sub_lt_fwd", 0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b1000, 4'b0110, 0);
        step("add_wrap",   0,  0,  0,  1,  1, FLG_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h0,        0,  4'b1000, 4'b1000, 1);
        step("adc_b2b",    0,  0,  0,  1,  1, FLG_ADC,   32'hFFFFFFFF, 32'h00000001, 32'h0,        0,  4'b0110, 4'b1000, 1);
        step("adc_zero",   0,  0,  0,  1,  1, FLG_ADC,   32'h0,        32'h0,        32'h0,        0,  4'b0010, 4'b0110, 1);
        step("adc_fwd",    0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0000, 4'b0010, 0);
        step("add_v",      0,  0,  0,  1,  1, FLG_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h0,        0,  4'b0000, 4'b0000, 1);
        step("add_v_fwd",  0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b1001, 4'b0000, 0);
        step("logic_v",    0,  0,  0,  1,  1, FLG_LOGIC, 32'h0,        32'h0,        32'h80000000, 1,  4'b1001, 4'b1001, 1);
        step("no_s",       0,  0,  0,  1,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b1011, 4'b1001, 0);
        step("rsvd_op",    0,  0,  0,  1,  1, 3'b101,    32'h1,        32'h1,        32'h0,        0,  4'b1011, 4'b1011, 0);
        step("rsvd_hold",  0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b1011, 4'b1011, 0);
        step("add_v2",     0,  0,  0,  1,  1, FLG_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h0,        0,  4'b1011, 4'b1011, 1);
        step("logic_b2b",  0,  0,  0,  1,  1, FLG_LOGIC, 32'h0,        32'h0,        32'h00000001, 0,  4'b1001, 4'b1011, 1);
        step("logic_fwd",  0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0001, 4'b1001, 0);
        step("logic_arch", 0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0001, 4'b0001, 0);
        step("flush_ex",   0,  0,  1,  1,  1, FLG_SUB,   32'd3,        32'd5,        32'h0,        0,  4'b0001, 4'b0001, 1);
        step("flush_ex_a", 0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0001, 4'b0001, 0);
        step("sub_for_p",  0,  0,  0,  1,  1, FLG_SUB,   32'd3,        32'd5,        32'h0,        0,  4'b0001, 4'b0001, 1);
        step("flush_p",    0,  0,  1,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b1000, 4'b0001, 0);
        step("flush_p_a",  0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0001, 4'b0001, 0);
        step("add_stall",  0,  0,  0,  1,  1, FLG_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h0,        0,  4'b0001, 4'b0001, 1);
        step("stall_1",    0,  1,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0110, 4'b0001, 0);
        step("stall_2",    0,  1,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0110, 4'b0001, 0);
        step("stall_3",    0,  1,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0110, 4'b0001, 0);
        step("stall_rel",  0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0110, 4'b0001, 0);
        step("stall_cmt",  0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0110, 4'b0110, 0);
        step("sub_fs",     0,  0,  0,  1,  1, FLG_SUB,   32'd3,        32'd5,        32'h0,        0,  4'b0110, 4'b0110, 1);
        step("flush_stall",0,  1,  1,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b1000, 4'b0110, 0);
        step("fs_after",   0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0110, 4'b0110, 0);
        step("add_rst",    0,  0,  0,  1,  1, FLG_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h0,        0,  4'b0110, 4'b0110, 1);
        step("rst_mid",    1,  0,  0,  1,  1, FLG_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h0,        0,  4'b0000, 4'b0000, 0);
        step("rst_after",  0,  0,  0,  0,  0, FLG_LOGIC, 32'h0,        32'h0,        32'h0,        0,  4'b0000, 4'b0000, 0);

        for (int i = 0; i < 5 && sb_q.size() != 0; i++)
            @(posedge clk);
        n_checks++;
        if (sb_q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
